// File: rtl/dds_core.sv
// dds_core: byte-command driven direct digital synthesis engine.
//
// A parser FSM decodes bytes from the UART into three actions: load the
// waveform table, set the frequency tuning word, and start/stop/clear playback.
// A phase accumulator addresses the table. The sample goes through a
// registered RAM read and then an output register to the DAC pins.
//
// Ports:
//   pll_clk    system clock
//   rst_n      synchronous active-low reset
//   rx_dv      one-cycle strobe qualifying rx_byte (clock enable, not a clock)
//   rx_byte    received command/data byte
//   dds_out    registered DAC word
//   running    playback enabled
//   loading    table load in progress
//   load_addr  next table write address
//   cmd_err    one-cycle pulse on unknown opcode or mid-command timeout
module dds_core #(
  parameter int DATA_SZ = 6,
  parameter int ADDR_SZ = 8,
  parameter int PHASE_W = 32,
  parameter int TIMEOUT = 75000
) (
  input  logic               pll_clk,
  input  logic               rst_n,
  input  logic               rx_dv,
  input  logic [7:0]         rx_byte,
  output logic [DATA_SZ-1:0] dds_out,
  output logic               running,
  output logic               loading,
  output logic [ADDR_SZ-1:0] load_addr,
  output logic               cmd_err
);

  localparam int NBYTES = PHASE_W / 8;
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [7:0]      FREQ_LAST = 8'(NBYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FREQ} state_t;

  state_t              state, state_nxt;
  logic                err_nxt;
  logic                timeout_hit;
  logic [TO_W-1:0]     to_cnt;
  logic [7:0]          byte_cnt;
  logic [PHASE_W-1:0]  shadow;
  logic [PHASE_W-1:0]  shift_word;
  logic [PHASE_W-1:0]  ftw;
  logic [PHASE_W-1:0]  acc_p0;
  logic [ADDR_SZ-1:0]  rd_addr_p0;
  logic                vld_p0;
  logic [DATA_SZ-1:0]  rd_data_p1;
  logic                vld_p1;

  logic op_load, op_freq, op_run, op_stop, op_clr;
  logic ram_we, freq_shift, freq_commit;

  logic [DATA_SZ-1:0] ram [2**ADDR_SZ];

  // The byte wins a tie with expiry: a strobe on the expiry cycle keeps the command alive.
  assign timeout_hit = (state != S_IDLE) && !rx_dv && (to_cnt == TO_LAST);
  assign shift_word  = PHASE_W'({shadow, rx_byte});

  // State register
  always_ff @(posedge pll_clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_dv) begin
          case (rx_byte)
            8'h01:               state_nxt = S_LOAD;
            8'h02:               state_nxt = S_FREQ;
            8'h03, 8'h04, 8'h05: state_nxt = S_IDLE;
            default:             err_nxt   = 1'b1;
          endcase
        end
      end
      S_LOAD: begin
        if (timeout_hit) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end else if (rx_dv && (load_addr == '1)) begin
          state_nxt = S_IDLE;
        end
      end
      S_FREQ: begin
        if (timeout_hit) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end else if (rx_dv && (byte_cnt == FREQ_LAST)) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output / strobe decode
  always_comb begin
    loading     = (state == S_LOAD);
    op_load     = (state == S_IDLE) && rx_dv && (rx_byte == 8'h01);
    op_freq     = (state == S_IDLE) && rx_dv && (rx_byte == 8'h02);
    op_run      = (state == S_IDLE) && rx_dv && (rx_byte == 8'h03);
    op_stop     = (state == S_IDLE) && rx_dv && (rx_byte == 8'h04);
    op_clr      = (state == S_IDLE) && rx_dv && (rx_byte == 8'h05);
    ram_we      = (state == S_LOAD) && rx_dv;
    freq_shift  = (state == S_FREQ) && rx_dv;
    freq_commit = freq_shift && (byte_cnt == FREQ_LAST);
  end

  // Parser datapath and control registers
  always_ff @(posedge pll_clk) begin
    if (!rst_n) begin
      cmd_err   <= 1'b0;
      running   <= 1'b0;
      load_addr <= '0;
      byte_cnt  <= '0;
      to_cnt    <= '0;
      shadow    <= '0;
      ftw       <= '0;
    end else begin
      cmd_err <= err_nxt;

      if (op_run)       running <= 1'b1;
      else if (op_stop) running <= 1'b0;

      // load_addr wraps naturally after the last table entry.
      if (op_load)     load_addr <= '0;
      else if (ram_we) load_addr <= load_addr + 1'b1;

      if (op_freq)         byte_cnt <= '0;
      else if (freq_shift) byte_cnt <= byte_cnt + 8'd1;

      if (state == S_IDLE || rx_dv || timeout_hit) to_cnt <= '0;
      else                                         to_cnt <= to_cnt + 1'b1;

      // An abandoned partial word is dropped so it can never leak into ftw.
      if (op_freq || timeout_hit) shadow <= '0;
      else if (freq_shift)        shadow <= shift_word;

      if (freq_commit) ftw <= shift_word;
    end
  end

  // Table write port (contents survive reset)
  always_ff @(posedge pll_clk) begin
    if (ram_we) ram[load_addr] <= rx_byte[7 -: DATA_SZ];
  end

  // Stage p0: phase accumulator
  assign rd_addr_p0 = acc_p0[PHASE_W-1 -: ADDR_SZ];
  assign vld_p0     = running;

  always_ff @(posedge pll_clk) begin
    if (!rst_n)       acc_p0 <= '0;
    else if (op_clr)  acc_p0 <= '0;
    else if (running) acc_p0 <= acc_p0 + ftw;
  end

  // Stage p1: registered table read (read-first against the write port)
  always_ff @(posedge pll_clk) begin
    if (vld_p0) rd_data_p1 <= ram[rd_addr_p0];
  end

  always_ff @(posedge pll_clk) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= vld_p0;
  end

  // Stage p2: DAC output register, frozen once the pipeline drains
  always_ff @(posedge pll_clk) begin
    if (!rst_n)      dds_out <= '0;
    else if (vld_p1) dds_out <= rd_data_p1;
  end

endmodule

// File: tb/tb_dds_core.sv
module tb_dds_core;

  localparam int DATA_SZ = 6;
  localparam int ADDR_SZ = 8;
  localparam int PHASE_W = 32;
  localparam int TIMEOUT = 100;

  logic               pll_clk = 1'b0;
  logic               rst_n   = 1'b0;
  logic               rx_dv   = 1'b0;
  logic [7:0]         rx_byte = 8'h00;
  logic [DATA_SZ-1:0] dds_out;
  logic               running;
  logic               loading;
  logic [ADDR_SZ-1:0] load_addr;
  logic               cmd_err;

  int n_checks = 0;
  int n_errors = 0;
  int err_seen = 0;

  dds_core #(
    .DATA_SZ(DATA_SZ),
    .ADDR_SZ(ADDR_SZ),
    .PHASE_W(PHASE_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .pll_clk  (pll_clk),
    .rst_n    (rst_n),
    .rx_dv    (rx_dv),
    .rx_byte  (rx_byte),
    .dds_out  (dds_out),
    .running  (running),
    .loading  (loading),
    .load_addr(load_addr),
    .cmd_err  (cmd_err)
  );

  always #5 pll_clk = ~pll_clk;

  always @(negedge pll_clk) if (cmd_err === 1'b1) err_seen++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic put(input logic [7:0] b);
    @(negedge pll_clk);
    rx_dv   = 1'b1;
    rx_byte = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge pll_clk);
      rx_dv = 1'b0;
    end
  endtask

  task automatic set_ftw(input logic [31:0] w);
    put(8'h02);
    for (int i = 3; i >= 0; i--) put(w[i*8 +: 8]);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge pll_clk);
    n_checks++;
    if ({dds_out, running, loading, load_addr, cmd_err} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got dds=%0h run=%0b load=%0b addr=%0h err=%0b expected all 0",
               dds_out, running, loading, load_addr, cmd_err);
    end
    rst_n = 1'b1;
    idle(2);
    n_checks++;
    if ({dds_out, running, loading, load_addr, cmd_err} !== '0) begin
      n_errors++;
      $display("FAIL reset_release: got dds=%0h run=%0b load=%0b addr=%0h err=%0b expected all 0",
               dds_out, running, loading, load_addr, cmd_err);
    end
  endtask

  task automatic test_load_ramp;
    put(8'h01);
    for (int k = 0; k < 256; k++) begin
      put(8'(k * 4));
      n_checks++;
      if ({loading, load_addr} !== {1'b1, 8'(k)}) begin
        n_errors++;
        $display("FAIL load_progress k=%0d: got loading=%0b addr=%0d expected loading=1 addr=%0d",
                 k, loading, load_addr, k);
      end
    end
    idle(1);
    n_checks++;
    if ({loading, load_addr, cmd_err} !== {1'b0, 8'd0, 1'b0}) begin
      n_errors++;
      $display("FAIL load_done: got loading=%0b addr=%0d err=%0b expected 0 0 0",
               loading, load_addr, cmd_err);
    end
  endtask

  task automatic test_play;
    set_ftw(32'h0100_0000);
    put(8'h03);
    put(8'h05);
    idle(3);
    for (int i = 0; i < 70; i++) begin
      if (i > 0) idle(1);
      n_checks++;
      if (dds_out !== 6'(i)) begin
        n_errors++;
        $display("FAIL play_step i=%0d: got %0d expected %0d", i, dds_out, i % 64);
      end
    end
    n_checks++;
    if (running !== 1'b1) begin
      n_errors++;
      $display("FAIL play_running: got %0b expected 1", running);
    end
  endtask

  task automatic test_unknown_stop;
    logic [DATA_SZ-1:0] frozen;
    put(8'h7E);
    idle(1);
    n_checks++;
    if ({cmd_err, running, loading} !== 3'b110) begin
      n_errors++;
      $display("FAIL unknown_pulse: got err=%0b run=%0b load=%0b expected 1 1 0",
               cmd_err, running, loading);
    end
    idle(1);
    n_checks++;
    if (cmd_err !== 1'b0) begin
      n_errors++;
      $display("FAIL unknown_width: got err=%0b expected 0", cmd_err);
    end
    put(8'h04);
    idle(4);
    frozen = dds_out;
    n_checks++;
    if (running !== 1'b0) begin
      n_errors++;
      $display("FAIL stop_running: got %0b expected 0", running);
    end
    idle(10);
    n_checks++;
    if (dds_out !== frozen) begin
      n_errors++;
      $display("FAIL stop_frozen: got %0d expected %0d", dds_out, frozen);
    end
  endtask

  task automatic test_timeout;
    int pulses;
    int first;
    logic [DATA_SZ-1:0] d0;
    pulses = 0;
    first  = 0;
    put(8'h02);
    put(8'hFF);
    put(8'hFF);
    for (int i = 1; i <= 150; i++) begin
      idle(1);
      if (cmd_err === 1'b1) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    n_checks++;
    if (pulses != 1) begin
      n_errors++;
      $display("FAIL timeout_pulses: got %0d expected 1", pulses);
    end
    n_checks++;
    if (first != TIMEOUT + 1) begin
      n_errors++;
      $display("FAIL timeout_latency: got %0d expected %0d", first, TIMEOUT + 1);
    end
    put(8'h03);
    idle(1);
    n_checks++;
    if (running !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout_next_opcode: got running=%0b expected 1", running);
    end
    idle(4);
    d0 = dds_out;
    idle(1);
    n_checks++;
    if (dds_out !== 6'(d0 + 6'd1)) begin
      n_errors++;
      $display("FAIL timeout_ftw_kept: got %0d expected %0d", dds_out, 6'(d0 + 6'd1));
    end
  endtask

  task automatic test_timeout_race;
    int e0;
    logic [DATA_SZ-1:0] d0;
    e0 = err_seen;
    put(8'h02);
    put(8'h02);
    idle(TIMEOUT - 1);
    put(8'h00);
    put(8'h00);
    put(8'h00);
    idle(5);
    n_checks++;
    if (err_seen != e0) begin
      n_errors++;
      $display("FAIL race_no_abort: got %0d cmd_err pulses expected 0", err_seen - e0);
    end
    d0 = dds_out;
    idle(1);
    n_checks++;
    if (dds_out !== 6'(d0 + 6'd2)) begin
      n_errors++;
      $display("FAIL race_ftw_commit: got %0d expected %0d", dds_out, 6'(d0 + 6'd2));
    end
  endtask

  task automatic test_reset_mid_load;
    int e0;
    put(8'h01);
    for (int k = 0; k < 10; k++) put(8'((k + 40) * 4));
    idle(1);
    n_checks++;
    if ({loading, load_addr} !== {1'b1, 8'd10}) begin
      n_errors++;
      $display("FAIL midload_progress: got loading=%0b addr=%0d expected 1 10", loading, load_addr);
    end
    e0 = err_seen;
    rst_n = 1'b0;
    idle(2);
    n_checks++;
    if ({loading, load_addr, running, cmd_err, dds_out} !== '0) begin
      n_errors++;
      $display("FAIL midload_reset: got load=%0b addr=%0d run=%0b err=%0b dds=%0d expected all 0",
               loading, load_addr, running, cmd_err, dds_out);
    end
    rst_n = 1'b1;
    idle(3);
    n_checks++;
    if (err_seen != e0 || loading !== 1'b0) begin
      n_errors++;
      $display("FAIL midload_no_err: got pulses=%0d loading=%0b expected 0 0",
               err_seen - e0, loading);
    end
    set_ftw(32'h0100_0000);
    put(8'h03);
    put(8'h05);
    idle(3);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) idle(1);
      n_checks++;
      if (dds_out !== 6'(40 + i)) begin
        n_errors++;
        $display("FAIL midload_ram i=%0d: got %0d expected %0d", i, dds_out, 40 + i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_ramp();
    test_play();
    test_unknown_stop();
    test_timeout();
    test_timeout_race();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
